st_ready_latency_fifo_adapter: RTL and testbench
================================================

# st_ready_latency_fifo_adapter

Avalon Streaming timing adapter for 32-bit packet streams. The upstream source runs with readyLatency = 1; the downstream sink uses a plain valid/ready handshake with readyLatency = 0. Beats already in flight when the downstream sink stalls are absorbed in a small internal FIFO, so no beat is ever lost. The block sits in the pixel streaming path between latency-1 producers (DMA readers, frame readers) and latency-0 consumers (filters, output formatters).

## Interface
- DEPTH, 4, FIFO entries; power of 2 and at least 2; at least 4 required for full throughput.
- clk  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- in_ready  out  1  registered; high in cycle t permits a beat in cycle t+1.
- in_valid  in  1  beat present; legal only in the cycle after in_ready was high.
- in_data  in  32  payload data.
- in_startofpacket  in  1  first beat of the packet.
- in_endofpacket  in  1  last beat of the packet.
- in_empty  in  2  number of unused bytes in an EOP beat.
- out_ready  in  1  downstream accepts this cycle (latency 0).
- out_valid  out  1  FIFO head is valid.
- out_data  out  32  head payload data.
- out_startofpacket  out  1  head start of packet.
- out_endofpacket  out  1  head end of packet.
- out_empty  out  2  head empty count.
- protocol_error  out  1  sticky error flag; port exists only with ADAPTER_PROTOCOL_CHECK_EN.

## Operation
- Storage: a DEPTH x 36 memory holding {data, sop, eop, empty}, plus write pointer, read pointer and count.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
  - count is log2(DEPTH)+1 bits wide and ranges 0..DEPTH.
- Push: push = in_valid && in_ready_d, where in_ready_d is in_ready delayed one cycle.
  - A beat with in_valid high while in_ready_d is low is discarded, and the payload is not written.
- Pop: pop = out_valid && out_ready.
- Outputs: out_valid = (count != 0), and out_* are read combinationally from mem[rd_ptr].
  - Payload is don't-care while out_valid is low.
- Count update: count_next = count + push - pop. A simultaneous push and pop leaves count unchanged, including at count = DEPTH-1.
- Ready generation: in_ready <= (count_next <= DEPTH-2). This guarantees that a beat arriving one cycle later always finds a free slot, even when a push occurs in the same cycle.
- Full: count never exceeds DEPTH. With legal input, a push into a full FIFO cannot occur.
- Packet fields pass through unmodified. The block does no SOP/EOP checking.
- Reset (reset_n low at a clock edge):
  - count, rd_ptr, wr_ptr, in_ready, protocol_error all go to 0, so out_valid = 0.
  - Memory contents are not reset.
  - Reset mid-packet drops every stored beat. No partial packet is emitted afterwards.

## Timing
- in_ready first rises at the first rising edge where reset_n is sampled high.
- Latency: a beat accepted in cycle t is presented on out_* in cycle t+1 when the FIFO was empty.
- Throughput: one beat per cycle sustained when out_ready is held high and DEPTH >= 4.
- Stall: if out_ready drops in cycle t, in_ready drops no later than the edge at which count_next exceeds DEPTH-2. Beats already in flight (at most one) are stored.
- Resume: out_valid stays high and head data stays stable until popped. in_ready re-asserts one cycle after count_next <= DEPTH-2.

## Configuration
- ADAPTER_PROTOCOL_CHECK_EN
  - Defined: the protocol_error port and register exist. The register is set when in_valid && !in_ready_d, stays set until reset, and resets to 0.
  - Not defined: the port and register are absent. Illegal beats are still silently discarded.

## Test plan
- Reset then stream: release reset, then drive 8 beats with data 0x00000001..0x00000008 (SOP on the first, EOP with empty=2 on the last), out_ready=1.
  - Expect in_ready=1 one edge after release.
  - Expect each beat on out_* one cycle after acceptance, in order, with SOP/EOP/empty intact.
- Back-pressure: with DEPTH=4, hold out_ready=0 while streaming.
  - Expect in_ready to fall after at most 3 accepted beats and count to peak at ≤ 4.
  - Raise out_ready: all beats emerge in order with no loss or duplication, and in_ready re-asserts.
- Simultaneous push/pop at full boundary: keep count at 3 with alternating out_ready.
  - Expect count never to exceed 4 and data order preserved across pointer wrap (more than 8 beats).
- Illegal beat: drive in_valid=1 with data 0xDEADBEEF in a cycle following in_ready=0.
  - Expect the beat never to appear on the output.
  - With ADAPTER_PROTOCOL_CHECK_EN, expect protocol_error=1 from the next edge, cleared only by reset.
- Reset mid-packet: assert reset_n=0 for 1 cycle with 3 beats stored.
  - Expect out_valid=0 and in_ready=0 after the edge.
  - A following packet of 2 beats emerges alone and correct.

Source files
------------

// File: rtl/st_ready_latency_fifo_adapter.sv
// st_ready_latency_fifo_adapter
//
// Avalon-ST timing adapter for 32-bit packet streams.
// - Upstream side: readyLatency = 1. A beat may only arrive in the cycle after in_ready was high.
// - Downstream side: readyLatency = 0, using a plain valid/ready handshake.
// - A small FIFO absorbs the beat that is still in flight when the sink stalls, so no beat is lost.
//
// Handshake semantics:
// - Upstream: a beat is accepted when in_valid is high in the cycle after in_ready was high
//   (in_ready_d). A beat offered while in_ready_d is low is discarded.
// - Downstream: a beat transfers in the cycle where out_valid && out_ready.
//   out_valid stays high and out_* stay stable until that transfer happens.
//
// Optional feature macro: ADAPTER_PROTOCOL_CHECK_EN
// - Adds a sticky protocol_error output.
// - protocol_error is set by any beat offered while in_ready_d is low.

module st_ready_latency_fifo_adapter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [1:0]  in_empty,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [1:0]  out_empty
`ifdef ADAPTER_PROTOCOL_CHECK_EN
    ,
    output logic        protocol_error
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = 36;
    // Highest occupancy after which one more in-flight beat still fits.
    localparam logic [AW:0] READY_LIMIT = (AW + 1)'(DEPTH - 2);

    // Each entry is packed as {data, sop, eop, empty}.
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          in_ready_d;
    logic          push;
    logic          pop;
    logic [WW-1:0] head;

    // Handshake qualification and next occupancy.
    always_comb begin
        push       = in_valid && in_ready_d;
        pop        = out_valid && out_ready;
        count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // The head of the FIFO drives the downstream side combinationally.
    always_comb begin
        head              = mem[rd_ptr];
        out_valid         = (count != '0);
        out_data          = head[35:4];
        out_startofpacket = head[3];
        out_endofpacket   = head[2];
        out_empty         = head[1:0];
    end

    // Payload storage. The memory is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data, in_startofpacket, in_endofpacket, in_empty};
        end
    end

    // Pointers, occupancy and registered ready. Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready   <= 1'b0;
            in_ready_d <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            // Leave room for the beat that may arrive next cycle on the old ready.
            in_ready   <= (count_next <= READY_LIMIT);
            in_ready_d <= in_ready;
        end
    end

`ifdef ADAPTER_PROTOCOL_CHECK_EN
    // Sticky flag for beats offered outside the ready window. It is cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            protocol_error <= 1'b0;
        end else if (in_valid && !in_ready_d) begin
            protocol_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_st_ready_latency_fifo_adapter.sv
// Self-checking bench for st_ready_latency_fifo_adapter (DEPTH = 4).
// The reference model is a beat queue plus the ready rules stated in plain terms.
module tb_st_ready_latency_fifo_adapter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_ready;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_startofpacket = 1'b0;
  logic        in_endofpacket = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
`ifdef ADAPTER_PROTOCOL_CHECK_EN
  logic        protocol_error;
`endif

  always #5 clk = ~clk;

  st_ready_latency_fifo_adapter #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .in_empty(in_empty),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_empty(out_empty)
`ifdef ADAPTER_PROTOCOL_CHECK_EN
    ,
    .protocol_error(protocol_error)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];
  logic m_ready = 1'b0;
  logic m_ready_d = 1'b0;
  logic m_perr = 1'b0;
  int pops = 0;
  int pushes = 0;
  int max_count = 0;
  bit seen_dead = 1'b0;

  // One clock of stimulus. The model advances and the scoreboard compares outputs #1 after the edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] emp, input logic ordy);
    logic push;
    logic pop;
    in_valid = iv; in_data = d; in_startofpacket = s; in_endofpacket = e;
    in_empty = emp; out_ready = ordy;
    pop  = (exp_q.size() != 0) && ordy;
    push = iv && m_ready_d;
    @(posedge clk); #1;
    if (!reset_n) begin
      exp_q.delete(); m_ready = 1'b0; m_ready_d = 1'b0; m_perr = 1'b0;
    end else begin
      if (iv && !m_ready_d) m_perr = 1'b1;
      if (pop) begin void'(exp_q.pop_front()); pops++; end
      if (push) begin exp_q.push_back({d, s, e, emp}); pushes++; end
      m_ready_d = m_ready;
      m_ready = (exp_q.size() <= DEPTH - 2);
    end
    if (exp_q.size() > max_count) max_count = exp_q.size();
    checks++;
    if (in_ready !== m_ready) begin
      failures++; $display("FAIL sb_in_ready: got %b expected %b", in_ready, m_ready);
    end
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      failures++; $display("FAIL sb_out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if ({out_data, out_startofpacket, out_endofpacket, out_empty} !== exp_q[0]) begin
        failures++;
        $display("FAIL sb_head: got %h expected %h",
                 {out_data, out_startofpacket, out_endofpacket, out_empty}, exp_q[0]);
      end
    end
    checks++;
    if (int'(dut.count) !== exp_q.size()) begin
      failures++; $display("FAIL sb_count: got %0d expected %0d", dut.count, exp_q.size());
    end
    if (out_valid === 1'b1 && out_data === 32'hDEADBEEF) seen_dead = 1'b1;
`ifdef ADAPTER_PROTOCOL_CHECK_EN
    checks++;
    if (protocol_error !== m_perr) begin
      failures++; $display("FAIL sb_protocol_error: got %b expected %b", protocol_error, m_perr);
    end
`endif
  endtask

  // Pops until the model queue is empty. The wait is bounded.
  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_state: got ready=%b valid=%b expected 0 0", in_ready, out_valid);
    end
    reset_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int p0 = pops;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      logic iv;
      iv = m_ready_d;
      step(iv, 32'(sent + 1), sent == 0, sent == 7, (sent == 7) ? 2'd2 : 2'd0, 1'b1);
      if (iv) begin
        sent++;
        if (sent == 1) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== 32'h1 || out_startofpacket !== 1'b1) begin
            failures++;
            $display("FAIL stream_latency: got valid=%b data=%h sop=%b expected 1 00000001 1",
                     out_valid, out_data, out_startofpacket);
          end
        end
      end
    end
    drain();
    checks++;
    if (pops - p0 !== 8) begin
      failures++; $display("FAIL stream_count: got %0d beats expected 8", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int p0 = pops;
    max_count = 0;
    for (int c = 0; c < 8; c++) begin
      logic iv;
      iv = m_ready_d;
      step(iv, $urandom, c == 0, 1'b0, 2'd0, 1'b0);
      if (iv) acc++;
    end
    checks++;
    if (in_ready !== 1'b0 || max_count > DEPTH) begin
      failures++; $display("FAIL bp_stall: got ready=%b peak=%0d expected 0 <=%0d", in_ready, max_count, DEPTH);
    end
    checks++;
    if (acc !== DEPTH) begin
      failures++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH);
    end
    drain();
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    checks++;
    if (pops - p0 !== acc || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_resume: got pops=%0d ready=%b expected %0d 1", pops - p0, in_ready, acc);
    end
  endtask

  task automatic test_full_boundary();
    int p0 = pushes;
    max_count = 0;
    for (int c = 0; c < 40; c++) step(m_ready_d, $urandom, 1'b0, 1'b0, 2'(c), c[0]);
    drain();
    checks++;
    if (pushes - p0 <= 8 || max_count > DEPTH) begin
      failures++; $display("FAIL boundary: got pushes=%0d peak=%0d expected >8 <=%0d", pushes - p0, max_count, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 200; c++)
      step(m_ready_d && ($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom_range(0, 1)));
    drain();
  endtask

  task automatic test_illegal();
    for (int c = 0; c < 10 && m_ready_d; c++) step(m_ready_d, $urandom, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 2'd3, 1'b0);
    checks++;
    if (int'(dut.count) !== DEPTH) begin
      failures++; $display("FAIL illegal_count: got %0d expected %0d", dut.count, DEPTH);
    end
`ifdef ADAPTER_PROTOCOL_CHECK_EN
    checks++;
    if (protocol_error !== 1'b1) begin
      failures++; $display("FAIL illegal_flag: got %b expected 1", protocol_error);
    end
`endif
    drain();
    checks++;
    if (seen_dead !== 1'b0) begin
      failures++; $display("FAIL illegal_leak: got 1 expected 0");
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    for (int c = 0; c < 10 && exp_q.size() < 3; c++) step(m_ready_d, $urandom, c == 0, 1'b0, 2'd0, 1'b0);
    checks++;
    if (int'(dut.count) !== 3) begin
      failures++; $display("FAIL mid_fill: got %0d expected 3", dut.count);
    end
    reset_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got valid=%b ready=%b expected 0 0", out_valid, in_ready);
    end
    p0 = pops;
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int c = 0, n = 0; c < 10 && n < 2; c++) begin
      logic iv;
      iv = m_ready_d;
      step(iv, 32'hA0 + 32'(n), n == 0, n == 1, (n == 1) ? 2'd1 : 2'd0, 1'b1);
      if (iv) n++;
    end
    drain();
    checks++;
    if (pops - p0 !== 2) begin
      failures++; $display("FAIL mid_packet: got %0d beats expected 2", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_boundary();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
